// File: rtl/brg_sram_1024x8_req_ctrl.sv
// Request-side controller for the 1024x8 single-port SRAM wrapper: issues one access per cycle
// and buffers fixed 1-cycle read data in a small response FIFO sized by read credits.
module brg_sram_1024x8_req_ctrl #(
    parameter int width_p       = 8,
    parameter int els_p         = 1024,
    parameter int addr_width_lp = $clog2(els_p),
    parameter int fifo_els_p    = 3
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,

    input  logic                     req_v_i,
    output logic                     req_ready_o,
    input  logic                     req_w_i,
    input  logic [addr_width_lp-1:0] req_addr_i,
    input  logic [width_p-1:0]       req_data_i,

    output logic                     resp_v_o,
    input  logic                     resp_ready_i,
    output logic [width_p-1:0]       resp_data_o,

    output logic                     sram_v_o,
    output logic                     sram_w_o,
    output logic [addr_width_lp-1:0] sram_addr_o,
    output logic [width_p-1:0]       sram_data_o,
    input  logic [width_p-1:0]       sram_data_i
);

    localparam int ptr_w_lp = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int cnt_w_lp = $clog2(fifo_els_p + 1);
    localparam logic [cnt_w_lp:0]   fifo_els_lp = (cnt_w_lp + 1)'(fifo_els_p);
    localparam logic [ptr_w_lp-1:0] ptr_last_lp = ptr_w_lp'(fifo_els_p - 1);

    logic [width_p-1:0]  mem_r [fifo_els_p];
    logic [ptr_w_lp-1:0] wr_ptr_r;
    logic [ptr_w_lp-1:0] rd_ptr_r;
    logic [cnt_w_lp-1:0] count_r;
    logic                inflight_r;

    logic credit;
    logic accept;
    logic push;
    logic pop;

    function automatic logic [ptr_w_lp-1:0] ptr_next(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_last_lp) ? '0 : p + ptr_w_lp'(1);
    endfunction

    // Credits use registered occupancy only; a same-cycle pop frees a slot one cycle later.
    assign credit = ({1'b0, count_r} + {{cnt_w_lp{1'b0}}, inflight_r}) < fifo_els_lp;

    assign req_ready_o = reset_n_i & (req_w_i | credit);
    assign accept      = req_v_i & req_ready_o;

    assign sram_v_o    = accept;
    assign sram_w_o    = req_w_i;
    assign sram_addr_o = req_addr_i;
    assign sram_data_o = req_data_i;

    assign push        = inflight_r;
    assign resp_v_o    = (count_r != '0);
    assign pop         = resp_v_o & resp_ready_i;
    assign resp_data_o = mem_r[rd_ptr_r];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            inflight_r <= 1'b0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
        end else begin
            inflight_r <= accept & ~req_w_i;
            if (push) wr_ptr_r <= ptr_next(wr_ptr_r);
            if (pop)  rd_ptr_r <= ptr_next(rd_ptr_r);
            case ({push, pop})
                2'b10:   count_r <= count_r + cnt_w_lp'(1);
                2'b01:   count_r <= count_r - cnt_w_lp'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Payload storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (push) mem_r[wr_ptr_r] <= sram_data_i;
    end

endmodule

// File: doc/brg_sram_1024x8_req_ctrl.md
# brg_sram_1024x8_req_ctrl

Request-side controller for the 28nm 1024x8 single-port SRAM wrapper. It turns a valid/ready request stream (reads and writes) from a core or test engine into one-access-per-cycle SRAM port activity. It captures read data on the fixed 1-cycle SRAM latency into a small response FIFO, so a stalled consumer never loses data. It sits between the requester and the SRAM wrapper, which it drives directly.

## Interface
- width_p, 8, data width; must match the SRAM.
- els_p, 1024, SRAM depth.
- addr_width_lp, 10, address width, $clog2(els_p).
- fifo_els_p, 3, response FIFO depth; must be at least 2. A value of 3 or more gives full read throughput.

- clk_i  in  1  single clock; all state updates on rising edge.
- reset_n_i  in  1  reset, asynchronous, active-low.
- req_v_i  in  1  request valid.
- req_ready_o  out  1  request accepted when req_v_i & req_ready_o.
- req_w_i  in  1  1 = write, 0 = read.
- req_addr_i  in  addr_width_lp  request address.
- req_data_i  in  width_p  write data.
- resp_v_o  out  1  read response valid.
- resp_ready_i  in  1  consumer accepts the response when resp_v_o & resp_ready_i.
- resp_data_o  out  width_p  read data.
- sram_v_o  out  1  to the SRAM v_i.
- sram_w_o  out  1  to the SRAM w_i.
- sram_addr_o  out  addr_width_lp  to the SRAM addr_i.
- sram_data_o  out  width_p  to the SRAM data_i.
- sram_data_i  in  width_p  from the SRAM data_o.

## Operation
- **Internal state**
  - inflight_r (1 bit): a read was issued last cycle.
  - Response FIFO: fifo_els_p entries, with wr_ptr/rd_ptr wrapping mod fifo_els_p and count_r in 0..fifo_els_p.
- **Credit rule for reads:** a read is allowed when count_r + inflight_r < fifo_els_p, using registered values only. A pop in the same cycle does not add credit until the next cycle.
- **req_ready_o**
  - = ~req_w_i ? credit : 1'b1.
  - It depends combinationally on req_w_i only, never on req_v_i.
  - It is forced to 0 while reset_n_i is low.
- **Issue**
  - sram_v_o = req_v_i & req_ready_o.
  - sram_w_o, sram_addr_o and sram_data_o pass req_w_i, req_addr_i and req_data_i through combinationally.
  - When sram_v_o = 0, these three pass-through outputs are don't-care.
- **Read capture**
  - inflight_r <= accepted & ~req_w_i.
  - When inflight_r = 1, sram_data_i is pushed into the FIFO at the end of that cycle.
  - The credit rule guarantees the FIFO is never full on a push. Overflow is a bench assertion.
- **Writes** produce no response and never consume credit. A write may issue while reads are outstanding.
- **Output:** resp_v_o = (count_r != 0). resp_data_o = the entry at rd_ptr, registered with no bypass.
- **Push and pop in the same cycle:** count_r is unchanged and both pointers advance.
- **Ordering:** responses are returned in read-issue order.

## Timing
- **Reset (reset_n_i low, asynchronous):**
  - count_r = 0, inflight_r = 0, wr_ptr = rd_ptr = 0.
  - resp_v_o = 0, req_ready_o = 0, sram_v_o = 0.
  - FIFO data contents are not reset.
- **First cycle after deassertion:** req_ready_o = 1.
- **Reset mid-operation:** any in-flight read and all queued responses are discarded, and nothing is emitted after release.
- **Read latency:** a read accepted in cycle N
  - has its SRAM access at the edge ending cycle N,
  - has sram_data_i valid during cycle N+1 and pushed at the end of N+1,
  - has resp_v_o = 1 in cycle N+2.
- **Throughput:** with resp_ready_i held high and fifo_els_p >= 3, one read per cycle is sustained. With fifo_els_p = 2, back-to-back reads stall one cycle in three.
- **Backpressure:** with resp_ready_i low, at most fifo_els_p reads are accepted. req_ready_o then drops for reads but stays 1 for writes.
- **Capture constraint:** sram_data_i is sampled only in the cycle after a read issue. The SRAM's hold-last-value behaviour is never relied on.

## Test plan
- **Reset:** hold reset_n_i low for 3 cycles with req_v_i = 1. Required: sram_v_o = 0, req_ready_o = 0, resp_v_o = 0. After release, req_ready_o = 1.
- **Write then read:** write 0xA5 to address 0x3FF, then read 0x3FF. Required: resp_v_o rises exactly 2 cycles after read acceptance with resp_data_o = 0xA5. The write produces no response.
- **Streaming reads:** write addresses 0..15 with data = addr ^ 0x5A, then issue 16 back-to-back reads with resp_ready_i = 1. Required: 16 consecutive responses, one per cycle, in order, with no req_ready_o gaps.
- **Backpressure:** with resp_ready_i = 0, offer 5 reads. Required:
  - exactly 3 are accepted, then req_ready_o = 0 with req_w_i = 0;
  - a write offered in this state is accepted;
  - after resp_ready_i = 1, the 3 responses drain in order and reads resume.
- **Push and pop at full:** with count_r = 2, inflight_r = 1 and resp_ready_i = 1, check count_r stays at 2 and pointers wrap past fifo_els_p - 1 correctly over 10 reads.
- **Reset mid-operation:** pulse reset_n_i low asynchronously, mid-cycle, while 2 responses are queued and 1 read is in flight. Required: resp_v_o falls immediately and no stale response appears after release.
